// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports and a sequential clear engine.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITEENABLE,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   input  logic                  CLEAR,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2,
   output logic                  BUSY
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] CLEARING = 1'b1;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] clearCount;
   logic                  writeHit;

   // A write lands only from IDLE with no clear request and never on the hard-wired zero entry.
   always_comb begin
      writeHit = WRITEENABLE && (state == IDLE) && !CLEAR
                 && !((ZERO_REG != 0) && (INADDRESS == '0));
   end

   function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] value;
      value = regs[addr];
      if (RESET || (state == CLEARING)) begin
         value = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
         value = '0;
      end
`ifdef REG_FILE_BYPASS_EN
      else if (writeHit && (addr == INADDRESS)) begin
         value = IN;
      end
`endif
      return value;
   endfunction

   always_comb begin
      OUT1 = readPort(OUT1ADDRESS);
      OUT2 = readPort(OUT2ADDRESS);
      BUSY = (state == CLEARING);
   end

   // Clear engine walks the file one entry per cycle; the counter stops at the last index.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         state      <= IDLE;
         clearCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (CLEAR) begin
                  state      <= CLEARING;
                  clearCount <= '0;
               end else if (writeHit) begin
                  regs[INADDRESS] <= IN;
               end
            end
            CLEARING: begin
               regs[clearCount] <= '0;
               if (clearCount == LAST_INDEX) begin
                  state <= IDLE;
               end else begin
                  clearCount <= clearCount + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: stimulus pushes expected values, a negedge monitor compares them.
// Runs against both ZERO_REG settings; bypass expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file_param;

   logic        clock;
   logic        reset;
   logic [31:0] inData;
   logic [4:0]  inAddress;
   logic        writeEnable;
   logic [4:0]  out1Address;
   logic [4:0]  out2Address;
   logic        clear;
   logic [31:0] out1;
   logic [31:0] out2;
   logic        busy;
   logic [31:0] out1NoZero;
   logic [31:0] out2NoZero;
   logic        busyNoZero;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } expEntry;

   expEntry expQ[$];
   expEntry cur;

`ifdef REG_FILE_BYPASS_EN
   localparam logic [31:0] BYPASS_22   = 32'h22;
   localparam logic [31:0] BYPASS_66   = 32'h66;
`else
   localparam logic [31:0] BYPASS_22   = 32'h11;
   localparam logic [31:0] BYPASS_66   = 32'h0;
`endif

   reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
      .CLK(clock), .RESET(reset), .IN(inData), .INADDRESS(inAddress),
      .WRITEENABLE(writeEnable), .OUT1ADDRESS(out1Address), .OUT2ADDRESS(out2Address),
      .CLEAR(clear), .OUT1(out1), .OUT2(out2), .BUSY(busy)
   );

   reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dutNoZero (
      .CLK(clock), .RESET(reset), .IN(inData), .INADDRESS(inAddress),
      .WRITEENABLE(writeEnable), .OUT1ADDRESS(out1Address), .OUT2ADDRESS(out2Address),
      .CLEAR(clear), .OUT1(out1NoZero), .OUT2(out2NoZero), .BUSY(busyNoZero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: every falling edge drains the expectations queued since the last one.
   always @(negedge clock) begin
      logic [31:0] actual;
      while (expQ.size() > 0) begin
         cur = expQ.pop_front();
         case (cur.sel)
            0:       actual = out1;
            1:       actual = out2;
            2:       actual = {31'b0, busy};
            default: actual = out1NoZero;
         endcase
         vectorCount++;
         if (actual !== cur.val) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", cur.name, actual, cur.val);
         end
      end
   end

   // Watchdog stops a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic expectOut(input string name, input int sel, input logic [31:0] val);
      expEntry e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      expQ.push_back(e);
   endtask

   task automatic checkNow(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
      inAddress   = addr;
      inData      = data;
      writeEnable = 1'b1;
      stepCycle();
      writeEnable = 1'b0;
   endtask

   task automatic checkOutput(input int hitAddr, input logic [31:0] hitVal);
      logic [31:0] exp1;
      logic [31:0] exp2;
      for (int i = 0; i < 32; i++) begin
         out1Address = 5'(i);
         out2Address = 5'(31 - i);
         exp1 = (i == hitAddr) ? hitVal : 32'h0;
         exp2 = ((31 - i) == hitAddr) ? hitVal : 32'h0;
         expectOut($sformatf("sweep port1 addr %0d", i), 0, exp1);
         expectOut($sformatf("sweep port2 addr %0d", 31 - i), 1, exp2);
         #1;
         vectorCount++;
         if (out1 !== exp1) begin
            missCount++;
            $display("[TB] FAIL direct sweep port1 addr %0d: got %h, expected %h", i, out1, exp1);
         end
         vectorCount++;
         if (out2 !== exp2) begin
            missCount++;
            $display("[TB] FAIL direct sweep port2 addr %0d: got %h, expected %h", 31 - i, out2, exp2);
         end
         stepCycle();
      end
   endtask

   // Main stimulus sequence covering every verification requirement in order.
   initial begin
      reset       = 1'b1;
      inData      = '0;
      inAddress   = '0;
      writeEnable = 1'b0;
      out1Address = 5'd5;
      out2Address = 5'd7;
      clear       = 1'b0;

      inAddress   = 5'd5;
      inData      = 32'hFFFF_FFFF;
      writeEnable = 1'b1;
      expectOut("reset busy", 2, 32'h0);
      expectOut("reset out1", 0, 32'h0);
      expectOut("reset out2", 1, 32'h0);
      stepCycle();
      writeEnable = 1'b0;
      expectOut("write ignored in reset", 0, 32'h0);
      stepCycle();
      reset = 1'b0;

      applyStimulus(5'd5, 32'hDEAD_BEEF);
      out1Address = 5'd5;
      out2Address = 5'd5;
      expectOut("basic port1", 0, 32'hDEAD_BEEF);
      expectOut("basic port2", 1, 32'hDEAD_BEEF);
      stepCycle();
      out2Address = 5'd7;
      expectOut("independent port2 empty", 1, 32'h0);
      stepCycle();

      applyStimulus(5'd0, 32'h1234_5678);
      out1Address = 5'd0;
      #1;
      checkNow("direct zero reg protected", out1, 32'h0);
      checkNow("direct zero reg disabled", out1NoZero, 32'h1234_5678);
      expectOut("zero reg protected", 0, 32'h0);
      expectOut("zero reg disabled", 3, 32'h1234_5678);
      stepCycle();

      applyStimulus(5'd7, 32'h11);
      out1Address = 5'd7;
      inAddress   = 5'd7;
      inData      = 32'h22;
      writeEnable = 1'b1;
      expectOut("bypass before edge", 0, BYPASS_22);
      stepCycle();
      writeEnable = 1'b0;
      expectOut("bypass after edge", 0, 32'h22);
      stepCycle();

      applyStimulus(5'd3, 32'h33);
      out1Address = 5'd3;
      clear       = 1'b1;
      writeEnable = 1'b1;
      inAddress   = 5'd3;
      inData      = 32'hAA;
      expectOut("clear+write no bypass", 0, 32'h33);
      stepCycle();
      clear       = 1'b0;
      writeEnable = 1'b0;
      expectOut("clear+write busy", 2, 32'h1);
      repeat (32) stepCycle();
      expectOut("clear+write busy done", 2, 32'h0);
      expectOut("clear+write addr3", 0, 32'h0);
      stepCycle();

      for (int i = 0; i < 32; i++) begin
         applyStimulus(5'(i), 32'hA000_0000 | i);
      end
      out1Address = 5'd31;
      out2Address = 5'd9;
      expectOut("fill addr31", 0, 32'hA000_001F);
      expectOut("fill addr9", 1, 32'hA000_0009);
      clear = 1'b1;
      stepCycle();
      clear = 1'b0;
      for (int k = 0; k < 32; k++) begin
         expectOut($sformatf("clear busy cycle %0d", k), 2, 32'h1);
         expectOut($sformatf("clear out1 zero cycle %0d", k), 0, 32'h0);
         if (k == 5) begin
            writeEnable = 1'b1;
            inAddress   = 5'd9;
            inData      = 32'h55;
            clear       = 1'b1;
         end
         stepCycle();
         writeEnable = 1'b0;
         clear       = 1'b0;
      end
      expectOut("clear busy fell", 2, 32'h0);
      applyStimulus(5'd4, 32'h44);
      checkOutput(4, 32'h44);

      applyStimulus(5'd20, 32'h77);
      applyStimulus(5'd25, 32'h88);
      clear = 1'b1;
      stepCycle();
      clear = 1'b0;
      repeat (10) stepCycle();
      reset       = 1'b1;
      writeEnable = 1'b1;
      inAddress   = 5'd6;
      inData      = 32'h66;
      out1Address = 5'd20;
      out2Address = 5'd25;
      #1;
      checkNow("direct midclear reset busy", {31'b0, busy}, 32'h0);
      checkNow("direct midclear reset addr20", out1, 32'h0);
      checkNow("direct midclear reset addr25", out2, 32'h0);
      expectOut("midclear reset busy", 2, 32'h0);
      expectOut("midclear reset addr20", 0, 32'h0);
      expectOut("midclear reset addr25", 1, 32'h0);
      stepCycle();
      out1Address = 5'd6;
      expectOut("write ignored in reset 2", 0, 32'h0);
      stepCycle();
      reset = 1'b0;
      expectOut("post reset bypass", 0, BYPASS_66);
      stepCycle();
      writeEnable = 1'b0;
      expectOut("post reset write", 0, 32'h66);
      expectOut("post reset busy", 2, 32'h0);
      stepCycle();
      checkOutput(6, 32'h66);

      stepCycle();
      stepCycle();
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the register and data-port width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter ZERO_REG, default 1, makes register 0 read as constant zero when set to 1.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 IN  input  DATA_WIDTH  write data.
REQ-007 INADDRESS  input  ADDR_WIDTH  write address.
REQ-008 WRITEENABLE  input  1  write request, sampled at the rising edge of CLK.
REQ-009 OUT1ADDRESS, OUT2ADDRESS  input  ADDR_WIDTH each  read addresses for ports 1 and 2.
REQ-010 CLEAR  input  1  request for a sequential zeroing of the whole file.
REQ-011 OUT1, OUT2  output  DATA_WIDTH each  combinational read data.
REQ-012 BUSY  output  1  high while a clear sequence is in progress.

Function
REQ-013 Reads SHALL be combinational with zero cycles of latency and no behavioural delays: OUTn = register[OUTnADDRESS].
REQ-014 A write SHALL occur at a rising edge when WRITEENABLE=1, the FSM is in IDLE and CLEAR=0; the new value SHALL be visible on the read ports immediately after that edge.
REQ-015 When ZERO_REG=1, a write to address 0 SHALL be discarded, and a read of address 0 SHALL return 0 on both ports.
REQ-016 Both read ports SHALL be fully independent, and reads of the same address on both ports SHALL be legal.
REQ-017 The FSM SHALL have two states, IDLE and CLEARING, and SHALL reset to IDLE.
REQ-018 In IDLE, CLEAR=1 at a rising edge SHALL move the FSM to CLEARING with the clear counter at 0, and any write in that same cycle SHALL be dropped.
REQ-019 In CLEARING, the register at the clear-counter index SHALL be zeroed at each rising edge and the counter SHALL increment by one.
REQ-020 The zeroing at counter value DEPTH-1 SHALL return the FSM to IDLE, and the counter SHALL NOT wrap.
REQ-021 BUSY SHALL equal 1 exactly in CLEARING, giving DEPTH consecutive BUSY cycles per clear.
REQ-022 While BUSY=1, WRITEENABLE and CLEAR SHALL be ignored, and OUT1 and OUT2 SHALL read 0.
REQ-023 A write in the first cycle after BUSY falls SHALL be accepted normally.
REQ-024 A write to an out-of-range address is impossible by construction, because the address width covers exactly DEPTH entries.

Reset
REQ-025 RESET=1 SHALL immediately, without waiting for a clock edge, zero all registers, force the FSM to IDLE and zero the clear counter; BUSY SHALL be 0, and OUT1 and OUT2 SHALL be 0.
REQ-026 An assertion of RESET in the middle of a clear sequence SHALL abort it, and the file SHALL be all-zero with the FSM in IDLE.
REQ-027 While RESET=1, writes and CLEAR SHALL be ignored.
REQ-028 The first write SHALL be accepted at the first rising edge after RESET is deasserted.

Configuration
REQ-029 The macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REG_FILE_BYPASS_EN defined, write-to-read forwarding SHALL be enabled under all of these conditions: WRITEENABLE=1, IDLE, CLEAR=0, RESET=0, OUTnADDRESS=INADDRESS, and the address is not the ZERO_REG-protected address 0. Under those conditions OUTn SHALL return IN combinationally in the same cycle, before the edge.
REQ-031 Without REG_FILE_BYPASS_EN, OUTn SHALL return the stored old value until the write edge.

Verification
REQ-032 The bench SHALL cover a basic write and read: write 0xDEADBEEF to address 5, then set OUT1ADDRESS=5 and OUT2ADDRESS=5 -> both ports read 0xDEADBEEF after the edge.
REQ-033 The bench SHALL cover the zero register: with ZERO_REG=1, write 0x12345678 to address 0 -> OUT1 reads 0; with ZERO_REG=0 the same write reads back 0x12345678.
REQ-034 The bench SHALL cover bypass: OUT1ADDRESS=7 holding 0x11, with WRITEENABLE=1, INADDRESS=7 and IN=0x22 -> before the edge, OUT1 reads 0x22 with REG_FILE_BYPASS_EN defined and 0x11 without it.
REQ-035 The bench SHALL cover a clear sequence: fill all 32 registers with nonzero values, pulse CLEAR for one cycle -> BUSY is high for exactly 32 cycles, a write issued during BUSY is ignored, and all registers read 0 afterwards.
REQ-036 The bench SHALL cover a simultaneous clear and write: CLEAR=1 and WRITEENABLE=1 to address 3 with 0xAA in IDLE -> the write is dropped, and address 3 reads 0 after the clear.
REQ-037 The bench SHALL cover reset during a clear: assert RESET between clock edges at clear counter value 10 -> BUSY falls immediately without waiting for a clock edge, all registers read 0, and a write on the first edge after RESET deasserts is accepted.
